// File: rtl/mem_access_pkg.sv
// Shared constants, operation codes and state type for the MEM stage.
package mem_access_pkg;

    localparam logic RstEnable    = 1'b1;
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;
    localparam logic Stop         = 1'b1;
    localparam logic NoStop       = 1'b0;

    localparam int RegAddrBusW = 5;
    localparam int RegBusW     = 32;
    localparam int AluOpBusW   = 8;

    localparam logic [RegAddrBusW-1:0] NOPRegAddr = '0;
    localparam logic [RegBusW-1:0]     ZeroWord   = '0;

    localparam logic [AluOpBusW-1:0] EXE_LB_OP  = 8'hE0;
    localparam logic [AluOpBusW-1:0] EXE_LH_OP  = 8'hE1;
    localparam logic [AluOpBusW-1:0] EXE_LW_OP  = 8'hE3;
    localparam logic [AluOpBusW-1:0] EXE_LBU_OP = 8'hE4;
    localparam logic [AluOpBusW-1:0] EXE_LHU_OP = 8'hE5;
    localparam logic [AluOpBusW-1:0] EXE_SB_OP  = 8'hE8;
    localparam logic [AluOpBusW-1:0] EXE_SH_OP  = 8'hE9;
    localparam logic [AluOpBusW-1:0] EXE_SW_OP  = 8'hEB;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } mem_state_e;

    function automatic logic is_load(input logic [AluOpBusW-1:0] op);
        return (op == EXE_LB_OP)  || (op == EXE_LH_OP)  || (op == EXE_LW_OP) ||
               (op == EXE_LBU_OP) || (op == EXE_LHU_OP);
    endfunction

    function automatic logic is_store(input logic [AluOpBusW-1:0] op);
        return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data bus between the MEM stage and memory: request side plus single-cycle ack/rdata.
interface mem_access_if;
    import mem_access_pkg::*;

    logic               req;
    logic               we;
    logic [3:0]         sel;
    logic [RegBusW-1:0] addr;
    logic [RegBusW-1:0] wdata;
    logic               ack;
    logic [RegBusW-1:0] rdata;

    modport master (output req, we, sel, addr, wdata, input ack, rdata);
    modport slave  (input req, we, sel, addr, wdata, output ack, rdata);

endinterface

// File: rtl/mem_access_lane_align.sv
// Big-endian byte-lane steering: byte enables, replicated store data,
// extended load value and the misaligned-access flag.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [AluOpBusW-1:0] aluop,
    input  logic [1:0]           addr_lo,
    input  logic [RegBusW-1:0]   rdata,
    input  logic [RegBusW-1:0]   reg2,
    output logic [3:0]           sel,
    output logic [RegBusW-1:0]   store_data,
    output logic [RegBusW-1:0]   load_data,
    output logic                 misaligned
);

    logic [7:0]  byte_v;
    logic [3:0]  byte_sel;
    logic [15:0] half_v;
    logic [3:0]  half_sel;

    always_comb begin
        sel        = 4'b0000;
        store_data = ZeroWord;
        load_data  = ZeroWord;
        misaligned = 1'b0;
        byte_v     = rdata[31:24];
        byte_sel   = 4'b1000;
        half_v     = addr_lo[1] ? rdata[15:0] : rdata[31:16];
        half_sel   = addr_lo[1] ? 4'b0011 : 4'b1100;

        // Address 0 is the most significant lane.
        case (addr_lo)
            2'b00: begin byte_v = rdata[31:24]; byte_sel = 4'b1000; end
            2'b01: begin byte_v = rdata[23:16]; byte_sel = 4'b0100; end
            2'b10: begin byte_v = rdata[15:8];  byte_sel = 4'b0010; end
            default: begin byte_v = rdata[7:0]; byte_sel = 4'b0001; end
        endcase

        case (aluop)
            EXE_LB_OP: begin
                sel       = byte_sel;
                load_data = {{24{byte_v[7]}}, byte_v};
            end
            EXE_LBU_OP: begin
                sel       = byte_sel;
                load_data = {24'h000000, byte_v};
            end
            EXE_LH_OP: begin
                sel        = half_sel;
                load_data  = {{16{half_v[15]}}, half_v};
                misaligned = addr_lo[0];
            end
            EXE_LHU_OP: begin
                sel        = half_sel;
                load_data  = {16'h0000, half_v};
                misaligned = addr_lo[0];
            end
            EXE_LW_OP: begin
                sel        = 4'b1111;
                load_data  = rdata;
                misaligned = |addr_lo;
            end
            EXE_SB_OP: begin
                sel        = byte_sel;
                store_data = {4{reg2[7:0]}};
            end
            EXE_SH_OP: begin
                sel        = half_sel;
                store_data = {2{reg2[15:0]}};
                misaligned = addr_lo[0];
            end
            EXE_SW_OP: begin
                sel        = 4'b1111;
                store_data = reg2;
                misaligned = |addr_lo;
            end
            default: begin
                sel = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: issues loads/stores on the data bus, stalls until ack,
// then presents the aligned result to mem_wb.
module mem_access
    import mem_access_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [RegAddrBusW-1:0] mem_wd,
    input  logic                   mem_wreg,
    input  logic [RegBusW-1:0]     mem_wdata,
    input  logic [AluOpBusW-1:0]   mem_aluop,
    input  logic [RegBusW-1:0]     mem_addr,
    input  logic [RegBusW-1:0]     mem_reg2,
    output logic [RegAddrBusW-1:0] wb_wd,
    output logic                   wb_wreg,
    output logic [RegBusW-1:0]     wb_wdata,
    output logic                   stallreq,
    output logic                   mem_excpt,
    mem_access_if.master           dbus
);

    mem_state_e         state_q;
    mem_state_e         state_d;
    logic [RegBusW-1:0] rdata_q;
    logic               capture;
    logic               issue;
    logic               mem_op;
    logic [3:0]         lane_sel;
    logic [RegBusW-1:0] store_data;
    logic [RegBusW-1:0] load_data;
    logic               misaligned;

    assign mem_op = is_load(mem_aluop) || is_store(mem_aluop);

    // Load extension works from the captured word so DONE is independent of the bus.
    mem_lane_align u_lane_align (
        .aluop      (mem_aluop),
        .addr_lo    (mem_addr[1:0]),
        .rdata      (rdata_q),
        .reg2       (mem_reg2),
        .sel        (lane_sel),
        .store_data (store_data),
        .load_data  (load_data),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q <= IDLE;
            rdata_q <= ZeroWord;
        end else begin
            state_q <= state_d;
            if (capture) begin
                rdata_q <= dbus.rdata;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        capture    = 1'b0;
        issue      = 1'b0;
        wb_wd      = mem_wd;
        wb_wreg    = mem_wreg;
        wb_wdata   = mem_wdata;
        stallreq   = NoStop;
        mem_excpt  = 1'b0;
        dbus.req   = 1'b0;
        dbus.we    = WriteDisable;
        dbus.sel   = 4'b0000;
        dbus.addr  = ZeroWord;
        dbus.wdata = ZeroWord;

        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    if (misaligned) begin
                        mem_excpt = 1'b1;
                        wb_wreg   = WriteDisable;
                    end else begin
                        issue   = 1'b1;
                        capture = dbus.ack;
                        state_d = dbus.ack ? DONE : WAIT;
                    end
                end
            end
            WAIT: begin
                issue = 1'b1;
                if (dbus.ack) begin
                    capture = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (is_load(mem_aluop)) begin
                    wb_wdata = load_data;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Inputs are held by ctrl during the stall, so the bus stays stable in WAIT.
        if (issue) begin
            stallreq  = Stop;
            wb_wreg   = WriteDisable;
            dbus.req  = 1'b1;
            dbus.we   = is_store(mem_aluop) ? WriteEnable : WriteDisable;
            dbus.sel  = lane_sel;
            dbus.addr = {mem_addr[31:2], 2'b00};
            if (is_store(mem_aluop)) begin
                dbus.wdata = store_data;
            end
        end

        if (rst == RstEnable) begin
            capture    = 1'b0;
            wb_wd      = NOPRegAddr;
            wb_wreg    = WriteDisable;
            wb_wdata   = ZeroWord;
            stallreq   = NoStop;
            mem_excpt  = 1'b0;
            dbus.req   = 1'b0;
            dbus.we    = WriteDisable;
            dbus.sel   = 4'b0000;
            dbus.addr  = ZeroWord;
            dbus.wdata = ZeroWord;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed vector table, reset-in-WAIT
// sequence and randomized ops against a byte-shifting reference model.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_addr;
    logic [31:0] mem_reg2;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        stallreq;
    logic        mem_excpt;

    int checks = 0;
    int passed = 0;

    mem_access_if dbus();

    mem_access dut (
        .clk       (clk),
        .rst       (rst),
        .mem_wd    (mem_wd),
        .mem_wreg  (mem_wreg),
        .mem_wdata (mem_wdata),
        .mem_aluop (mem_aluop),
        .mem_addr  (mem_addr),
        .mem_reg2  (mem_reg2),
        .wb_wd     (wb_wd),
        .wb_wreg   (wb_wreg),
        .wb_wdata  (wb_wdata),
        .stallreq  (stallreq),
        .mem_excpt (mem_excpt),
        .dbus      (dbus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  aluop;
        logic [31:0] addr;
        logic [31:0] reg2;
        logic [31:0] rdata;
        int          nwait;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [3:0]  exp_sel;
        logic [31:0] exp_bus_wdata;
        logic [31:0] exp_result;
        logic        exp_excpt;
    } vec_t;

    vec_t vecs[13];

    // Reference model: access size in bytes, lanes counted from the MSB.
    function automatic int op_size(input logic [7:0] op);
        case (op)
            8'hE0, 8'hE4, 8'hE8: return 1;
            8'hE1, 8'hE5, 8'hE9: return 2;
            8'hE3, 8'hEB:        return 4;
            default:             return 0;
        endcase
    endfunction

    function automatic logic op_store(input logic [7:0] op);
        return (op == 8'hE8) || (op == 8'hE9) || (op == 8'hEB);
    endfunction

    function automatic logic model_misaligned(input logic [7:0] op, input logic [31:0] addr);
        int n = op_size(op);
        return (n > 0) && ((int'(addr[1:0]) % n) != 0);
    endfunction

    function automatic logic [3:0] model_sel(input logic [7:0] op, input logic [31:0] addr);
        int n   = op_size(op);
        int off = int'(addr[1:0]);
        int v   = ((1 << n) - 1) << (4 - n - off);
        return v[3:0];
    endfunction

    function automatic logic [31:0] model_store(input logic [7:0] op, input logic [31:0] reg2);
        int n = op_size(op);
        logic [31:0] d = 32'h0;
        for (int b = 0; b < 4; b++) begin
            d = d | (((reg2 >> (8 * (b % n))) & 32'hFF) << (8 * b));
        end
        return d;
    endfunction

    function automatic logic [31:0] model_load(input logic [7:0] op, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        int n   = op_size(op);
        int off = int'(addr[1:0]);
        logic [31:0] mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        logic [31:0] v    = (rdata >> (8 * (4 - n - off))) & mask;
        if (((op == 8'hE0) || (op == 8'hE1)) && ((v & ((mask >> 1) + 32'd1)) != 32'd0)) begin
            v = v | ~mask;
        end
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drives one instruction from the IDLE cycle through DONE, checking each cycle.
    task automatic applyStimulus(input string name, input vec_t v);
        logic is_mem = (op_size(v.aluop) > 0);
        @(negedge clk);
        mem_aluop  = v.aluop;
        mem_addr   = v.addr;
        mem_reg2   = v.reg2;
        mem_wd     = v.wd;
        mem_wreg   = v.wreg;
        mem_wdata  = v.wdata;
        dbus.ack   = (is_mem && !v.exp_excpt) ? (v.nwait == 0) : 1'($urandom_range(0, 1));
        dbus.rdata = (dbus.ack && is_mem) ? v.rdata : $urandom;
        #1;
        checkOutput({name, ".excpt"}, 32'(mem_excpt), 32'(v.exp_excpt));
        if (!is_mem) begin
            checkOutput({name, ".wd"},    32'(wb_wd),    32'(v.wd));
            checkOutput({name, ".wreg"},  32'(wb_wreg),  32'(v.wreg));
            checkOutput({name, ".wdata"}, wb_wdata,      v.wdata);
            checkOutput({name, ".stall"}, 32'(stallreq), 32'd0);
            checkOutput({name, ".req"},   32'(dbus.req), 32'd0);
            return;
        end
        if (v.exp_excpt) begin
            checkOutput({name, ".wreg"},  32'(wb_wreg),  32'd0);
            checkOutput({name, ".stall"}, 32'(stallreq), 32'd0);
            checkOutput({name, ".req"},   32'(dbus.req), 32'd0);
            return;
        end
        checkOutput({name, ".stall0"}, 32'(stallreq), 32'd1);
        checkOutput({name, ".req0"},   32'(dbus.req), 32'd1);
        checkOutput({name, ".wreg0"},  32'(wb_wreg),  32'd0);
        checkOutput({name, ".sel"},    32'(dbus.sel), 32'(v.exp_sel));
        checkOutput({name, ".we"},     32'(dbus.we),  32'(op_store(v.aluop)));
        checkOutput({name, ".addr"},   dbus.addr,     v.addr & 32'hFFFF_FFFC);
        if (op_store(v.aluop)) begin
            checkOutput({name, ".bwdata"}, dbus.wdata, v.exp_bus_wdata);
        end
        for (int i = 1; i <= v.nwait; i++) begin
            @(negedge clk);
            dbus.ack   = (i == v.nwait);
            dbus.rdata = dbus.ack ? v.rdata : $urandom;
            #1;
            checkOutput({name, ".stallw"}, 32'(stallreq), 32'd1);
            checkOutput({name, ".reqw"},   32'(dbus.req), 32'd1);
            checkOutput({name, ".selw"},   32'(dbus.sel), 32'(v.exp_sel));
        end
        @(negedge clk);
        dbus.ack   = 1'($urandom_range(0, 1));
        dbus.rdata = $urandom;
        #1;
        checkOutput({name, ".stall_done"}, 32'(stallreq), 32'd0);
        checkOutput({name, ".req_done"},   32'(dbus.req), 32'd0);
        checkOutput({name, ".wreg_done"},  32'(wb_wreg),  32'(v.wreg));
        checkOutput({name, ".wd_done"},    32'(wb_wd),    32'(v.wd));
        checkOutput({name, ".result"},     wb_wdata,      v.exp_result);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, ".wd"},     32'(wb_wd),     32'd0);
        checkOutput({name, ".wreg"},   32'(wb_wreg),   32'd0);
        checkOutput({name, ".wdata"},  wb_wdata,       32'd0);
        checkOutput({name, ".stall"},  32'(stallreq),  32'd0);
        checkOutput({name, ".excpt"},  32'(mem_excpt), 32'd0);
        checkOutput({name, ".req"},    32'(dbus.req),  32'd0);
        checkOutput({name, ".we"},     32'(dbus.we),   32'd0);
        checkOutput({name, ".sel"},    32'(dbus.sel),  32'd0);
        checkOutput({name, ".addr"},   dbus.addr,      32'd0);
        checkOutput({name, ".bwdata"}, dbus.wdata,     32'd0);
    endtask

    initial begin
        vec_t v;
        logic [7:0] ops[8];
        ops = '{8'hE0, 8'hE4, 8'hE1, 8'hE5, 8'hE3, 8'hE8, 8'hE9, 8'hEB};

        vecs[0]  = '{8'h25, 32'h0,     32'h0,        32'h0,        0, 5'd3, 1'b1, 32'h1234, 4'b0000, 32'h0,        32'h1234,     1'b0};
        vecs[1]  = '{8'hE0, 32'h101,   32'h0,        32'h11803344, 0, 5'd5, 1'b1, 32'h0,    4'b0100, 32'h0,        32'hFFFFFF80, 1'b0};
        vecs[2]  = '{8'hE5, 32'h102,   32'h0,        32'hAAAA8001, 3, 5'd6, 1'b1, 32'h0,    4'b0011, 32'h0,        32'h00008001, 1'b0};
        vecs[3]  = '{8'hE9, 32'h2,     32'hDEADBEEF, 32'h0,        1, 5'd0, 1'b0, 32'h55,   4'b0011, 32'hBEEFBEEF, 32'h55,       1'b0};
        vecs[4]  = '{8'hE3, 32'h6,     32'h0,        32'h0,        0, 5'd9, 1'b1, 32'h0,    4'b0000, 32'h0,        32'h0,        1'b1};
        vecs[5]  = '{8'hE8, 32'h3,     32'h123456EF, 32'h0,        0, 5'd0, 1'b0, 32'h77,   4'b0001, 32'hEFEFEFEF, 32'h77,       1'b0};
        vecs[6]  = '{8'hE1, 32'h0,     32'h0,        32'h80011234, 2, 5'd7, 1'b1, 32'h0,    4'b1100, 32'h0,        32'hFFFF8001, 1'b0};
        vecs[7]  = '{8'hE4, 32'h200,   32'h0,        32'h80FFFFFF, 0, 5'd8, 1'b1, 32'h0,    4'b1000, 32'h0,        32'h00000080, 1'b0};
        vecs[8]  = '{8'hE3, 32'h10,    32'h0,        32'h12345678, 1, 5'd10, 1'b1, 32'h0,   4'b1111, 32'h0,        32'h12345678, 1'b0};
        vecs[9]  = '{8'hEB, 32'h1C,    32'hCAFEF00D, 32'h0,        0, 5'd0, 1'b0, 32'h99,   4'b1111, 32'hCAFEF00D, 32'h99,       1'b0};
        vecs[10] = '{8'hE1, 32'h3,     32'h0,        32'h0,        0, 5'd11, 1'b1, 32'h0,   4'b0000, 32'h0,        32'h0,        1'b1};
        vecs[11] = '{8'hEB, 32'h2,     32'h0,        32'h0,        0, 5'd0, 1'b0, 32'h0,    4'b0000, 32'h0,        32'h0,        1'b1};
        vecs[12] = '{8'hE5, 32'h0,     32'h0,        32'hFEDC1234, 0, 5'd12, 1'b1, 32'h0,   4'b1100, 32'h0,        32'h0000FEDC, 1'b0};

        // Reset forces every output even with a live load and ack on the inputs.
        rst        = 1'b1;
        mem_aluop  = 8'hE3;
        mem_addr   = 32'h40;
        mem_reg2   = 32'h1;
        mem_wd     = 5'd4;
        mem_wreg   = 1'b1;
        mem_wdata  = 32'hABCD;
        dbus.ack   = 1'b1;
        dbus.rdata = 32'h5A5A5A5A;
        @(negedge clk);
        @(negedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset while waiting abandons the load; a later ack must not write back.
        @(negedge clk);
        mem_aluop = 8'hE3; mem_addr = 32'h20; mem_wd = 5'd7; mem_wreg = 1'b1;
        dbus.ack  = 1'b0;
        #1;
        checkOutput("rstwait.stall0", 32'(stallreq), 32'd1);
        @(negedge clk);
        #1;
        checkOutput("rstwait.stall1", 32'(stallreq), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkAllZero("rstwait.inreset");
        @(negedge clk);
        rst = 1'b0;
        mem_aluop = 8'h00; mem_addr = 32'h0; mem_wd = 5'd0; mem_wreg = 1'b0;
        mem_wdata = 32'h0; mem_reg2 = 32'h0;
        dbus.ack  = 1'b1;
        dbus.rdata = 32'hDEAD0001;
        #1;
        checkAllZero("rstwait.lateack");
        v = '{8'hE3, 32'h40, 32'h0, 32'h0BADF00D, 1, 5'd2, 1'b1, 32'h0, 4'b1111, 32'h0, 32'h0BADF00D, 1'b0};
        applyStimulus("rstwait.next", v);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                do v.aluop = 8'($urandom_range(0, 255)); while (op_size(v.aluop) != 0);
            end else begin
                v.aluop = ops[$urandom_range(0, 7)];
            end
            v.addr  = $urandom;
            if ((op_size(v.aluop) > 0) && ($urandom_range(0, 3) != 0)) begin
                v.addr = v.addr & ~(32'(op_size(v.aluop)) - 32'd1);
            end
            v.reg2          = $urandom;
            v.rdata         = $urandom;
            v.nwait         = $urandom_range(0, 3);
            v.wd            = 5'($urandom_range(0, 31));
            v.wreg          = 1'($urandom_range(0, 1));
            v.wdata         = $urandom;
            v.exp_excpt     = model_misaligned(v.aluop, v.addr);
            v.exp_sel       = (op_size(v.aluop) > 0) ? model_sel(v.aluop, v.addr) : 4'b0000;
            v.exp_bus_wdata = op_store(v.aluop) ? model_store(v.aluop, v.reg2) : 32'h0;
            v.exp_result    = (op_size(v.aluop) > 0 && !op_store(v.aluop))
                              ? model_load(v.aluop, v.addr, v.rdata) : v.wdata;
            applyStimulus($sformatf("rnd%0d", i), v);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
